// File: rtl/inst_prefetch_queue_if.sv
// Fetch-side bundle between inst_prefetch_queue, instruction memory and the IF/ID register.
// master: the prefetch queue; slave: the surrounding pipeline and memory.
interface inst_prefetch_queue_if;
    logic        stall;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] pc_out;

    modport master (
        input  stall, flush, redirect_pc, imem_valid, imem_data,
        output imem_req, imem_addr, inst_valid, inst_out, pc_out
    );

    modport slave (
        output stall, flush, redirect_pc, imem_valid, imem_data,
        input  imem_req, imem_addr, inst_valid, inst_out, pc_out
    );
endinterface

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues imem reads, buffers {inst, pc} for IF/ID.
// Define PFQ_BYPASS_EN to forward a response straight to IF/ID when the queue is empty.
module inst_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input logic                   clk,
    input logic                   rst,
    inst_prefetch_queue_if.master bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned SumW = CntW + 1;

    typedef enum logic [0:0] {StFetch, StDrain} state_e;

    state_e              state_q, state_d;
    logic [31:0]         fetch_pc_q, fetch_pc_d;
    logic [PtrW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [PtrW-1:0]     pc_wr_q, pc_wr_d, pc_rd_q, pc_rd_d;
    logic [CntW-1:0]     count_q, count_d, out_q, out_d, drop_q, drop_d;
    logic [31:0]         last_inst_q, last_inst_d, last_pc_q, last_pc_d;

    logic [31:0]         inst_mem  [DEPTH];
    logic [31:0]         pc_mem    [DEPTH];
    logic [31:0]         issue_pc  [DEPTH];

    logic [SumW-1:0]     used;
    logic [CntW-1:0]     resp_left;
    logic                fifo_nonempty, resp_pop, bypass, can_issue, issue, keep, pop;
    logic                cur_valid;
    logic [31:0]         cur_inst, cur_pc;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StFetch;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    // Next state: a flush reloads the stale-response count from what is still in flight
    always_comb begin
        state_d   = state_q;
        drop_d    = drop_q;
        resp_left = out_q - CntW'(resp_pop);
        if (bus.flush) begin
            drop_d  = resp_left;
            state_d = (resp_left != '0) ? StDrain : StFetch;
        end else if (state_q == StDrain && bus.imem_valid) begin
            drop_d = (drop_q != '0) ? drop_q - CntW'(1) : '0;
            if (drop_d == '0) begin
                state_d = StFetch;
            end
        end
    end

    // Outputs and handshake decode
    always_comb begin
        used          = SumW'(count_q) + SumW'(out_q);
        fifo_nonempty = (count_q != '0);
        resp_pop      = bus.imem_valid && (out_q != '0);
        bypass        = 1'b0;
`ifdef PFQ_BYPASS_EN
        bypass = rst && !fifo_nonempty && (drop_q == '0) && (state_q == StFetch) &&
                 !bus.stall && !bus.flush && bus.imem_valid;
`else
        bypass = 1'b0;
`endif
        if (state_q == StFetch) begin
            can_issue = (used < SumW'(DEPTH)) && (out_q < CntW'(MAX_OUT));
        end else begin
            can_issue = (out_q < CntW'(MAX_OUT));
        end
        // rst gates the comb outputs so they drop the instant reset asserts
        issue = rst && !bus.flush && can_issue;
        keep  = bus.imem_valid && !bus.flush && (state_q == StFetch) && (drop_q == '0) &&
                !bypass;
        pop   = fifo_nonempty && !bus.stall && !bus.flush;

        cur_valid = fifo_nonempty || bypass;
        if (fifo_nonempty) begin
            cur_inst = inst_mem[head_q];
            cur_pc   = pc_mem[head_q];
        end else if (bypass) begin
            cur_inst = bus.imem_data;
            cur_pc   = issue_pc[pc_rd_q];
        end else begin
            cur_inst = last_inst_q;
            cur_pc   = last_pc_q;
        end

        bus.imem_req   = issue;
        bus.imem_addr  = {2'b00, fetch_pc_q[31:2]};
        bus.inst_valid = cur_valid;
        bus.inst_out   = cur_inst;
        bus.pc_out     = cur_pc;
    end

    // Datapath next state
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        out_d       = out_q + CntW'(issue) - CntW'(resp_pop);
        pc_wr_d     = pc_wr_q + PtrW'(issue);
        pc_rd_d     = pc_rd_q + PtrW'(resp_pop);
        last_inst_d = last_inst_q;
        last_pc_d   = last_pc_q;
        if (bus.flush) begin
            fetch_pc_d = bus.redirect_pc & ~32'd3;
            count_d    = '0;
            head_d     = tail_q;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            count_d = count_q + CntW'(keep) - CntW'(pop);
            head_d  = head_q + PtrW'(pop);
            tail_d  = tail_q + PtrW'(keep);
        end
        // Remember what was shown so an empty queue keeps presenting it
        if (cur_valid) begin
            last_inst_d = cur_inst;
            last_pc_d   = cur_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q  <= RESET_PC;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            out_q       <= '0;
            pc_wr_q     <= '0;
            pc_rd_q     <= '0;
            last_inst_q <= '0;
            last_pc_q   <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            out_q       <= out_d;
            pc_wr_q     <= pc_wr_d;
            pc_rd_q     <= pc_rd_d;
            last_inst_q <= last_inst_d;
            last_pc_q   <= last_pc_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and counters
    always_ff @(posedge clk) begin
        if (issue) begin
            issue_pc[pc_wr_q] <= fetch_pc_q;
        end
        if (keep) begin
            inst_mem[tail_q] <= bus.imem_data;
            pc_mem[tail_q]   <= issue_pc[pc_rd_q];
        end
    end
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Randomized bench for inst_prefetch_queue against a queue-based reference model.
module tb_inst_prefetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'd0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    inst_prefetch_queue_if bus ();

    inst_prefetch_queue #(
        .DEPTH    (DEPTH),
        .MAX_OUT  (MAX_OUT),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model
    logic [31:0] m_fetch_pc;
    logic [31:0] m_inflight[$];
    logic [31:0] m_fifo[$];
    int          m_drop;
    logic [31:0] m_last_pc, m_last_inst;

    // Instruction memory model
    logic [31:0] pend_addr[$];
    int          pend_rdy[$];

    function automatic logic [31:0] data_of(input logic [31:0] waddr);
        return (waddr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_fetch_pc  = RESET_PC;
        m_inflight.delete();
        m_fifo.delete();
        m_drop      = 0;
        m_last_pc   = 32'd0;
        m_last_inst = 32'd0;
        pend_addr.delete();
        pend_rdy.delete();
    endtask

    // Entered at posedge+1; drives, samples, advances the model, returns at next posedge+1
    task automatic step(input int stall_pct, input int flush_pct, input int max_lat);
        logic [31:0] e_pc, e_inst, rpc;
        logic        e_valid, e_req, byp, resp;
        int          lat;
        resp = 1'b0;
        rpc  = 32'd0;
        if (pend_addr.size() > 0 && pend_rdy[0] <= cyc) begin
            resp           = 1'b1;
            bus.imem_valid = 1'b1;
            bus.imem_data  = data_of(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_rdy.pop_front());
        end else begin
            bus.imem_valid = 1'b0;
            bus.imem_data  = $urandom;
        end
        bus.stall = (int'($urandom_range(0, 99)) < stall_pct);
        bus.flush = (int'($urandom_range(0, 99)) < flush_pct);
        if ($urandom_range(0, 7) == 0) bus.redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        else                           bus.redirect_pc = $urandom & 32'h0000_0FFF;
        #1;

        byp = 1'b0;
`ifdef PFQ_BYPASS_EN
        byp = resp && (m_fifo.size() == 0) && (m_drop == 0) && !bus.stall && !bus.flush;
`endif
        e_valid = (m_fifo.size() != 0) || byp;
        if (m_fifo.size() != 0)                 e_pc = m_fifo[0];
        else if (byp && m_inflight.size() != 0) e_pc = m_inflight[0];
        else                                    e_pc = m_last_pc;
        e_inst = e_valid ? data_of(e_pc >> 2) : m_last_inst;
        e_req  = !bus.flush && (m_inflight.size() < MAX_OUT) &&
                 (m_drop > 0 || (m_fifo.size() + m_inflight.size()) < DEPTH);

        check_eq("inst_valid", {31'd0, bus.inst_valid}, {31'd0, e_valid});
        check_eq("pc_out", bus.pc_out, e_pc);
        check_eq("inst_out", bus.inst_out, e_inst);
        check_eq("imem_req", {31'd0, bus.imem_req}, {31'd0, e_req});
        if (e_req) check_eq("imem_addr", bus.imem_addr, m_fetch_pc >> 2);

        if (bus.imem_req) begin
            lat = int'($urandom_range(1, max_lat));
            pend_addr.push_back(bus.imem_addr);
            pend_rdy.push_back(cyc + lat);
        end

        if (e_valid) begin
            m_last_pc   = e_pc;
            m_last_inst = e_inst;
        end
        if (resp && m_inflight.size() > 0) rpc = m_inflight.pop_front();
        if (bus.flush) begin
            m_fifo.delete();
            m_drop     = m_inflight.size();
            m_fetch_pc = bus.redirect_pc & ~32'd3;
        end else begin
            if (e_valid && !bus.stall && !byp) void'(m_fifo.pop_front());
            if (resp) begin
                if (m_drop > 0) m_drop--;
                else if (!byp)  m_fifo.push_back(rpc);
            end
            if (e_req) begin
                m_inflight.push_back(m_fetch_pc);
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end

        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run(input int n, input int sp, input int fp, input int ml);
        for (int i = 0; i < n; i++) step(sp, fp, ml);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_inst_valid"}, {31'd0, bus.inst_valid}, 32'd0);
        check_eq({tag, "_imem_req"}, {31'd0, bus.imem_req}, 32'd0);
        check_eq({tag, "_inst_out"}, bus.inst_out, 32'd0);
        check_eq({tag, "_pc_out"}, bus.pc_out, 32'd0);
    endtask

    initial begin
        bus.stall       = 1'b0;
        bus.flush       = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.imem_valid  = 1'b0;
        bus.imem_data   = 32'd0;
        model_reset();
        #3;
        check_reset_outputs("reset");
        check_eq("reset_imem_addr", bus.imem_addr, RESET_PC >> 2);

        @(posedge clk);
        #1;
        rst = 1'b1;

        run(30, 0, 0, 1);    // straight-line fetch, 1-cycle memory
        run(60, 60, 0, 1);   // heavy stall fills the queue
        run(300, 25, 10, 3); // stalls, flushes, variable latency
        run(200, 10, 25, 4); // frequent flushes while draining

        // Asynchronous reset in the middle of a burst
        rst            = 1'b0;
        bus.imem_valid = 1'b1;
        bus.flush      = 1'b0;
        bus.stall      = 1'b0;
        #1;
        check_reset_outputs("midrst");
        bus.imem_valid = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        cyc += 2;
        #1;
        rst = 1'b1;
        run(20, 0, 0, 1);
        run(200, 20, 10, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_prefetch_queue.md
Name: inst_prefetch_queue

Overview:
- Fetch-side block upstream of the IF/ID pipeline register; sits between the instruction memory and IFID.
- Owns the fetch PC and issues word reads to instruction memory.
- Buffers returned instructions and their PCs in a small FIFO and presents the head entry to IFID.
- Absorbs IFID stalls and discards wrong-path instructions on a taken branch, jump or return.

Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- MAX_OUT, 2: maximum in-flight memory requests, range 1..DEPTH.
- RESET_PC, 32'd0: byte address of the first fetch after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  IFID hold (load-use hazard); head entry is not consumed.
- flush  in  1  redirect request (sel_pc asserted).
- redirect_pc  in  32  new fetch byte address, valid when flush=1.
- imem_req  out  1  read request, held for one cycle per request.
- imem_addr  out  32  word address {2'd0, fetch_pc[31:2]}.
- imem_valid  in  1  read data returned; responses return in order, latency 1 or more.
- imem_data  in  32  returned instruction word.
- inst_valid  out  1  head entry is valid.
- inst_out  out  32  head instruction.
- pc_out  out  32  byte PC of the head instruction.

Behaviour:
- Reset (async, rst=0):
  - fetch_pc=RESET_PC; FIFO head, tail and count=0; outstanding=0; drop_cnt=0; state=FETCH.
  - imem_req=0, inst_valid=0, inst_out=0, pc_out=0.
- State machine, two states:
  - FETCH: normal operation.
  - DRAIN: discarding stale responses after a flush.
- FETCH, issue:
  - imem_req=1 when count+outstanding<DEPTH and outstanding<MAX_OUT.
  - On issue, fetch_pc += 4 (32-bit wrap, no carry-out) and outstanding += 1.
- Response (imem_valid=1): outstanding -= 1.
  - In FETCH with drop_cnt=0: write {imem_data, PC} at the tail. The PC comes from a companion PC FIFO, pushed at issue time and popped at response.
- Dequeue:
  - inst_valid = (count!=0); inst_out and pc_out are driven combinationally from the head.
  - The head pops when inst_valid=1 and stall=0 and flush=0.
- Simultaneous push and pop: count is unchanged; head and tail both advance and wrap modulo DEPTH.
- Full: no issue while count+outstanding>=DEPTH, so the FIFO never overflows and imem responses are never back-pressured.
- Empty: inst_valid=0, and inst_out/pc_out hold the last head values. IFID treats inst_valid=0 as a bubble.
- Flush (highest priority, in any state):
  - FIFO count=0 and head=tail.
  - fetch_pc=redirect_pc.
  - No issue in the flush cycle.
  - drop_cnt = outstanding after this cycle's response is accounted.
  - Next state is DRAIN if drop_cnt>0, otherwise FETCH.
  - A response arriving in the flush cycle is discarded.
- DRAIN:
  - Each imem_valid decrements drop_cnt; data is discarded.
  - Issue is allowed while outstanding<MAX_OUT; new-path responses are kept once drop_cnt reaches 0.
  - Return to FETCH when drop_cnt reaches 0.
- Flush during DRAIN: drop_cnt is reloaded with the current outstanding count, and fetch_pc=redirect_pc.
- redirect_pc[1:0] is ignored; fetch_pc is forced word-aligned.
- stall and flush together: flush wins.
- Reset mid-operation: all state clears immediately; in-flight responses arriving after reset release are counted against drop_cnt=0 and accepted. The system must therefore hold imem in reset too.

Optional Feature:
- Macro: PFQ_BYPASS_EN.
- When defined: if count=0, drop_cnt=0, stall=0, flush=0 and imem_valid=1, the response drives inst_out/pc_out/inst_valid combinationally in the same cycle and is not written to the FIFO. Response-to-IFID latency is 0 cycles.
- When undefined: every response is written to the FIFO first and appears on inst_valid one cycle later; minimum latency is 1 cycle.

Test Plan:
1. Reset release, 1-cycle imem, no stall -> imem_addr sequence 0,1,2,3...; pc_out sequence 0,4,8,...; inst_valid continuously 1 after initial fill.
2. Stall held 6 cycles with DEPTH=4 -> count saturates at 4; imem_req=0 once count+outstanding=4; no entry lost; pc_out resumes at the stalled value +4 after release.
3. Flush with redirect_pc=0x100 while 2 requests are outstanding -> both stale responses dropped; next inst_valid shows pc_out=0x100; imem_addr=0x40.
4. Flush together with stall and imem_valid in the same cycle -> FIFO empty next cycle, response discarded, fetch_pc=0x100.
5. Back-to-back flushes to 0x200 then 0x300 during DRAIN -> only pc_out=0x300 instructions delivered.
6. rst=0 mid-burst -> inst_valid=0 and imem_req=0 asynchronously; after release imem_addr=RESET_PC>>2; with PFQ_BYPASS_EN the first instruction appears in the same cycle as imem_valid.
